// File: rtl/unidade_controle.sv
// Moore control FSM sequencing one GeoGenius match: drives the datapath
// clear/count/load strobes and keeps the registered acertou/errou result flags.
module unidade_controle #(
  parameter int ESPERA_ROM = 1
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       iniciar,
  input  logic       fez_jogada,
  input  logic       jogada_igual_memoria,
  input  logic       ultima_jogada,
  input  logic       deu_timeout,
  input  logic       fim_timer_resultado,
  output logic       zera_contador_jogada,
  output logic       zera_contador_score,
  output logic       zera_timer_resultado,
  output logic       zera_timeout,
  output logic       zeraR,
  output logic       zera_tempo_de_jogo,
  output logic       conta_jogada,
  output logic       conta_score,
  output logic       conta_timer_resultado,
  output logic       conta_timeout,
  output logic       registraR,
  output logic       liga_led,
  output logic       mostra_tempo_de_jogo,
  output logic       acertou,
  output logic       errou,
  output logic       pronto,
  output logic [3:0] db_estado
);

  localparam logic [3:0] INICIAL          = 4'h0;
  localparam logic [3:0] PREPARACAO       = 4'h1;
  localparam logic [3:0] ESPERA_ROM_ST    = 4'h2;
  localparam logic [3:0] MOSTRA_BANDEIRA  = 4'h3;
  localparam logic [3:0] COMPARA          = 4'h4;
  localparam logic [3:0] ACERTO           = 4'h5;
  localparam logic [3:0] ERRO             = 4'h6;
  localparam logic [3:0] MOSTRA_RESULTADO = 4'h7;
  localparam logic [3:0] PROXIMA          = 4'h8;
  localparam logic [3:0] FIM_JOGO         = 4'hF;

  localparam logic [1:0] ESPERA_ULTIMO = 2'(ESPERA_ROM - 1);

  logic [3:0] r_estado;
  logic [3:0] w_proximo;
  logic [1:0] r_espera;
  logic       r_acertou;
  logic       r_errou;

  always_comb begin
    w_proximo = INICIAL;
    case (r_estado)
      INICIAL:          w_proximo = iniciar ? PREPARACAO : INICIAL;
      PREPARACAO:       w_proximo = ESPERA_ROM_ST;
      ESPERA_ROM_ST:    w_proximo = (r_espera == ESPERA_ULTIMO) ? MOSTRA_BANDEIRA : ESPERA_ROM_ST;
      // A press in the same cycle as the timeout still counts as an answer.
      MOSTRA_BANDEIRA:  w_proximo = fez_jogada  ? COMPARA :
                                    deu_timeout ? ERRO    : MOSTRA_BANDEIRA;
      COMPARA:          w_proximo = jogada_igual_memoria ? ACERTO : ERRO;
      ACERTO:           w_proximo = MOSTRA_RESULTADO;
      ERRO:             w_proximo = MOSTRA_RESULTADO;
      MOSTRA_RESULTADO: w_proximo = !fim_timer_resultado ? MOSTRA_RESULTADO :
                                    ultima_jogada        ? FIM_JOGO : PROXIMA;
      PROXIMA:          w_proximo = ESPERA_ROM_ST;
      FIM_JOGO:         w_proximo = iniciar ? PREPARACAO : FIM_JOGO;
      default:          w_proximo = INICIAL;
    endcase
  end

  // Result flags follow the state being entered, so they are valid for the
  // whole stay in acerto/erro and cleared already while in proxima.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_estado  <= INICIAL;
      r_espera  <= 2'd0;
      r_acertou <= 1'b0;
      r_errou   <= 1'b0;
    end else begin
      r_estado <= w_proximo;
      r_espera <= (r_estado == ESPERA_ROM_ST) ? r_espera + 2'd1 : 2'd0;
      if (w_proximo == ACERTO) begin
        r_acertou <= 1'b1;
        r_errou   <= 1'b0;
      end else if (w_proximo == ERRO) begin
        r_acertou <= 1'b0;
        r_errou   <= 1'b1;
      end else if (w_proximo == PREPARACAO || w_proximo == PROXIMA) begin
        r_acertou <= 1'b0;
        r_errou   <= 1'b0;
      end
    end
  end

  always_comb begin
    zera_contador_jogada  = 1'b0;
    zera_contador_score   = 1'b0;
    zera_timer_resultado  = 1'b0;
    zera_timeout          = 1'b0;
    zeraR                 = 1'b0;
    zera_tempo_de_jogo    = 1'b0;
    conta_jogada          = 1'b0;
    conta_score           = 1'b0;
    conta_timer_resultado = 1'b0;
    conta_timeout         = 1'b0;
    registraR             = 1'b0;
    liga_led              = 1'b0;
    mostra_tempo_de_jogo  = 1'b0;
    pronto                = 1'b0;
    case (r_estado)
      PREPARACAO: begin
        zera_contador_jogada = 1'b1;
        zera_contador_score  = 1'b1;
        zera_timer_resultado = 1'b1;
        zera_timeout         = 1'b1;
        zeraR                = 1'b1;
        zera_tempo_de_jogo   = 1'b1;
      end
      ESPERA_ROM_ST: zera_timeout = 1'b1;
      MOSTRA_BANDEIRA: begin
        liga_led      = 1'b1;
        conta_timeout = 1'b1;
        registraR     = 1'b1;
      end
      COMPARA:          liga_led = 1'b1;
      ACERTO:           conta_score = 1'b1;
      MOSTRA_RESULTADO: conta_timer_resultado = 1'b1;
      PROXIMA: begin
        conta_jogada         = 1'b1;
        zera_timer_resultado = 1'b1;
        zeraR                = 1'b1;
      end
      FIM_JOGO: begin
        pronto               = 1'b1;
        mostra_tempo_de_jogo = 1'b1;
      end
      default: ;
    endcase
  end

  assign acertou   = r_acertou;
  assign errou     = r_errou;
  assign db_estado = r_estado;

endmodule

// File: tb/tb_unidade_controle.sv
// Directed bench for unidade_controle: walks reset, answers, timeout, a full
// four-flag match, async reset, and a second instance with ESPERA_ROM=3.
module tb_unidade_controle;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic reset, iniciar, fez_jogada, jogada_igual_memoria, ultima_jogada;
  logic deu_timeout, fim_timer_resultado;
  logic zera_contador_jogada, zera_contador_score, zera_timer_resultado, zera_timeout;
  logic zeraR, zera_tempo_de_jogo, conta_jogada, conta_score, conta_timer_resultado;
  logic conta_timeout, registraR, liga_led, mostra_tempo_de_jogo, acertou, errou, pronto;
  logic [3:0] db_estado;

  logic reset3, iniciar3;
  logic zcj3, zcs3, ztr3, zt3, zr3, ztj3, cj3, cs3, ctr3, ct3, rr3, ll3, mtj3, ac3, er3, pr3;
  logic [3:0] db_estado3;

  unidade_controle dut (
    .clock(clock), .reset(reset), .iniciar(iniciar), .fez_jogada(fez_jogada),
    .jogada_igual_memoria(jogada_igual_memoria), .ultima_jogada(ultima_jogada),
    .deu_timeout(deu_timeout), .fim_timer_resultado(fim_timer_resultado),
    .zera_contador_jogada(zera_contador_jogada), .zera_contador_score(zera_contador_score),
    .zera_timer_resultado(zera_timer_resultado), .zera_timeout(zera_timeout),
    .zeraR(zeraR), .zera_tempo_de_jogo(zera_tempo_de_jogo), .conta_jogada(conta_jogada),
    .conta_score(conta_score), .conta_timer_resultado(conta_timer_resultado),
    .conta_timeout(conta_timeout), .registraR(registraR), .liga_led(liga_led),
    .mostra_tempo_de_jogo(mostra_tempo_de_jogo), .acertou(acertou), .errou(errou),
    .pronto(pronto), .db_estado(db_estado)
  );

  unidade_controle #(.ESPERA_ROM(3)) dut3 (
    .clock(clock), .reset(reset3), .iniciar(iniciar3), .fez_jogada(1'b0),
    .jogada_igual_memoria(1'b0), .ultima_jogada(1'b0),
    .deu_timeout(1'b0), .fim_timer_resultado(1'b0),
    .zera_contador_jogada(zcj3), .zera_contador_score(zcs3),
    .zera_timer_resultado(ztr3), .zera_timeout(zt3),
    .zeraR(zr3), .zera_tempo_de_jogo(ztj3), .conta_jogada(cj3),
    .conta_score(cs3), .conta_timer_resultado(ctr3),
    .conta_timeout(ct3), .registraR(rr3), .liga_led(ll3),
    .mostra_tempo_de_jogo(mtj3), .acertou(ac3), .errou(er3),
    .pronto(pr3), .db_estado(db_estado3)
  );

  logic [13:0] w_ctl;
  assign w_ctl = {zera_contador_jogada, zera_contador_score, zera_timer_resultado,
                  zera_timeout, zeraR, zera_tempo_de_jogo, conta_jogada, conta_score,
                  conta_timer_resultado, conta_timeout, registraR, liga_led,
                  mostra_tempo_de_jogo, pronto};

  int n_vec = 0;
  int n_err = 0;
  int cnt_score = 0;
  int cnt_jogada = 0;
  logic [3:0] exp_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Expected control vector per state, straight from the state/output table.
  function automatic logic [13:0] exp_ctl(input logic [3:0] s);
    case (s)
      4'h1:    exp_ctl = 14'b11_1111_0000_0000;
      4'h2:    exp_ctl = 14'b00_0100_0000_0000;
      4'h3:    exp_ctl = 14'b00_0000_0001_1100;
      4'h4:    exp_ctl = 14'b00_0000_0000_0100;
      4'h5:    exp_ctl = 14'b00_0000_0100_0000;
      4'h7:    exp_ctl = 14'b00_0000_0010_0000;
      4'h8:    exp_ctl = 14'b00_1010_1000_0000;
      4'hF:    exp_ctl = 14'b00_0000_0000_0011;
      default: exp_ctl = 14'b0;
    endcase
  endfunction

  // One clock; outputs sampled 1ns after the rising edge.
  task automatic tick(input string tag, input logic [3:0] es);
    logic [3:0] e;
    exp_q.push_back(es);
    @(posedge clock);
    #1;
    if (conta_score)  cnt_score++;
    if (conta_jogada) cnt_jogada++;
    e = exp_q.pop_front();
    chk({tag, ".estado"}, 32'(db_estado), 32'(e));
    chk({tag, ".ctl"}, 32'(w_ctl), 32'(exp_ctl(e)));
  endtask

  // Starts in mostra_bandeira; answers one flag and returns to mostra_bandeira
  // (or stops in fim_jogo when last is set).
  task automatic play_flag(input logic correct, input logic last);
    fez_jogada = 1'b1; jogada_igual_memoria = correct;
    tick("flag_cmp", 4'h4);
    fez_jogada = 1'b0;
    tick("flag_res", correct ? 4'h5 : 4'h6);
    tick("flag_show", 4'h7);
    chk("flag_acertou", 32'(acertou), 32'(correct));
    chk("flag_errou", 32'(errou), 32'(!correct));
    fim_timer_resultado = 1'b1; ultima_jogada = last;
    tick("flag_next", last ? 4'hF : 4'h8);
    fim_timer_resultado = 1'b0; ultima_jogada = 1'b0;
    if (!last) begin
      tick("flag_rom", 4'h2);
      tick("flag_band", 4'h3);
    end
  endtask

  initial begin
    reset = 1'b0; reset3 = 1'b0; iniciar = 1'b0; iniciar3 = 1'b0;
    fez_jogada = 1'b0; jogada_igual_memoria = 1'b0; ultima_jogada = 1'b0;
    deu_timeout = 1'b0; fim_timer_resultado = 1'b0;

    // Reset and start
    for (int i = 0; i < 3; i++) tick("rst", 4'h0);
    chk("rst_acertou", 32'(acertou), 32'd0);
    chk("rst_errou", 32'(errou), 32'd0);
    reset = 1'b1; iniciar = 1'b1;
    tick("start_prep", 4'h1);
    iniciar = 1'b0;
    tick("start_rom", 4'h2);
    tick("start_band", 4'h3);

    // Correct answer, not last
    play_flag(1'b1, 1'b0);
    chk("prox_cnt_score", 32'(cnt_score), 32'd1);
    chk("prox_cnt_jogada", 32'(cnt_jogada), 32'd1);

    // Timeout counts as wrong
    tick("hold_band", 4'h3);
    deu_timeout = 1'b1;
    tick("to_erro", 4'h6);
    deu_timeout = 1'b0;
    chk("to_errou", 32'(errou), 32'd1);
    chk("to_acertou", 32'(acertou), 32'd0);
    tick("to_show", 4'h7);
    chk("to_cnt_score", 32'(cnt_score), 32'd1);
    fim_timer_resultado = 1'b1;
    tick("to_prox", 4'h8);
    fim_timer_resultado = 1'b0;
    chk("to_errou_clr", 32'(errou), 32'd0);
    tick("to_rom", 4'h2);
    tick("to_band", 4'h3);

    // Press and timeout together: press wins
    fez_jogada = 1'b1; deu_timeout = 1'b1; jogada_igual_memoria = 1'b0;
    tick("both_cmp", 4'h4);
    fez_jogada = 1'b0; deu_timeout = 1'b0;
    tick("both_erro", 4'h6);

    // Full match from a fresh reset: correct, wrong, correct, correct(last)
    reset = 1'b0;
    tick("m_rst", 4'h0);
    reset = 1'b1; iniciar = 1'b1;
    tick("m_prep", 4'h1);
    tick("m_rom", 4'h2);
    iniciar = 1'b0;
    tick("m_band", 4'h3);
    cnt_score = 0; cnt_jogada = 0;
    play_flag(1'b1, 1'b0);
    play_flag(1'b0, 1'b0);
    play_flag(1'b1, 1'b0);
    play_flag(1'b1, 1'b1);
    chk("m_cnt_score", 32'(cnt_score), 32'd3);
    chk("m_cnt_jogada", 32'(cnt_jogada), 32'd3);
    chk("m_pronto", 32'(pronto), 32'd1);
    tick("m_fim_hold", 4'hF);
    chk("m_fim_acertou", 32'(acertou), 32'd1);
    iniciar = 1'b1;
    tick("m_restart", 4'h1);
    iniciar = 1'b0;
    chk("m_restart_acertou", 32'(acertou), 32'd0);

    // Async reset between edges while in mostra_resultado
    tick("ar_rom", 4'h2);
    tick("ar_band", 4'h3);
    fez_jogada = 1'b1; jogada_igual_memoria = 1'b1;
    tick("ar_cmp", 4'h4);
    fez_jogada = 1'b0;
    tick("ar_acerto", 4'h5);
    tick("ar_show", 4'h7);
    #2 reset = 1'b0;
    #1;
    chk("ar_estado", 32'(db_estado), 32'h0);
    chk("ar_acertou", 32'(acertou), 32'd0);
    chk("ar_errou", 32'(errou), 32'd0);
    tick("ar_hold", 4'h0);
    reset = 1'b1;

    // ESPERA_ROM=3 instance: three cycles in espera_rom
    reset3 = 1'b1; iniciar3 = 1'b1;
    @(posedge clock); #1;
    chk("e3_prep", 32'(db_estado3), 32'h1);
    iniciar3 = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clock); #1;
      chk("e3_rom", 32'(db_estado3), 32'h2);
    end
    @(posedge clock); #1;
    chk("e3_band", 32'(db_estado3), 32'h3);
    chk("e3_led", 32'({ll3, rr3, ct3}), 32'b111);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/unidade_controle.md
Name: unidade_controle

Overview:
- Moore control FSM that sequences one GeoGenius match.
- Sits directly downstream of the game datapath's status outputs and drives every zera_/conta_/registraR/liga_led/tempo-de-jogo control input of that datapath.
- Consumes the datapath's timer, timeout, compare, last-play and press-detect flags.
- Produces result flags and a debug state code for the display.

Parameters:
- ESPERA_ROM, 1, cycles spent in espera_rom after the play address changes; covers the synchronous ROM read latency (range 1..3).

Ports:
- clock  in  1  system clock, all state updates on rising edge
- reset  in  1  asynchronous, active-low; forces state inicial and clears all registered flags
- iniciar  in  1  level; start/restart request
- fez_jogada  in  1  one-cycle press pulse from the datapath
- jogada_igual_memoria  in  1  registered button equals the ROM flag
- ultima_jogada  in  1  play counter at its last value for the current difficulty
- deu_timeout  in  1  answer time expired
- fim_timer_resultado  in  1  result display time elapsed
- zera_contador_jogada, zera_contador_score, zera_timer_resultado, zera_timeout, zeraR, zera_tempo_de_jogo  out  1 each  datapath clears
- conta_jogada, conta_score, conta_timer_resultado, conta_timeout  out  1 each  datapath count enables
- registraR  out  1  button register load
- liga_led  out  1  show the current flag on the LEDs
- mostra_tempo_de_jogo  out  1  expose elapsed game time
- acertou, errou  out  1 each  registered result flags
- pronto  out  1  match finished
- db_estado  out  4  current state code

Behaviour:
- Control outputs are decoded combinationally from the state register only (Moore). Each output not listed for a state is 0.
- acertou and errou are registers. Reset value of every output is that of inicial: all 0, db_estado = 0x0.

States, codes, asserted outputs, and transitions:
- inicial (0x0): no outputs asserted. Goes to preparacao when iniciar=1.
- preparacao (0x1): all six zera_* outputs asserted; clears acertou and errou. Goes unconditionally to espera_rom.
- espera_rom (0x2): zera_timeout. Stays ESPERA_ROM cycles, counted by an internal counter cleared on entry, then goes to mostra_bandeira.
- mostra_bandeira (0x3): liga_led, conta_timeout, registraR.
  - The register reloads every cycle, so the edge carrying fez_jogada captures the pressed buttons.
  - Priority: fez_jogada first, then go to compara. Otherwise deu_timeout, then go to erro. Otherwise stay.
  - If both arrive in the same cycle, the press wins.
- compara (0x4): liga_led. Goes to acerto if jogada_igual_memoria=1, else to erro.
- acerto (0x5): conta_score; sets acertou. Goes to mostra_resultado.
- erro (0x6): sets errou. Goes to mostra_resultado.
- mostra_resultado (0x7): conta_timer_resultado. On fim_timer_resultado, go to fim_jogo if ultima_jogada=1, else to proxima.
- proxima (0x8): conta_jogada, zera_timer_resultado, zeraR; clears acertou and errou. Goes to espera_rom.
- fim_jogo (0xF): pronto, mostra_tempo_de_jogo; acertou and errou hold their last values. Goes to preparacao when iniciar=1.

Timing and flag rules:
- Timeout counts as a wrong answer; the match continues to the next flag.
- conta_score pulses exactly once per correct answer; conta_jogada pulses exactly once per non-final flag.
- The game-time counter shares conta_timeout, so it advances only in mostra_bandeira.
- acertou and errou are mutually exclusive and never both 1.
- iniciar held high does not restart the match mid-play; it is sampled only in inicial and fim_jogo.

Reset and illegal states:
- reset low at any time forces inicial asynchronously.
- Release is synchronous to the next rising edge; no datapath count enable may pulse during the release cycle.
- Unused state codes go to inicial on the next edge.

Test Plan:
- Reset/start: reset=0 for 3 cycles, then 1 with iniciar=1. Required: db_estado 0x0 → 0x1 (six zera high for exactly 1 cycle) → 0x2 for 1 cycle → 0x3 with liga_led=1, registraR=1.
- Correct answer: in 0x3 pulse fez_jogada with jogada_igual_memoria=1. Required: 0x4 → 0x5 (conta_score 1 cycle) → 0x7 with acertou=1. fim_timer_resultado=1 and ultima_jogada=0 → 0x8 (conta_jogada 1 cycle, acertou cleared) → 0x2.
- Timeout: hold in 0x3, assert deu_timeout. Required: next state 0x6, errou=1, conta_score stays 0. Simultaneous fez_jogada+deu_timeout → 0x4.
- Full match: 4 flags (ultima_jogada raised on the 4th), answers correct/wrong/correct/correct. Required: exactly 3 conta_score pulses, 3 conta_jogada pulses, end in 0xF with pronto=1, mostra_tempo_de_jogo=1. iniciar=1 → 0x1.
- Async reset mid-match: drive reset=0 between clock edges while in 0x7. Required: db_estado=0x0 and acertou=errou=0 immediately, before the next edge.
- ESPERA_ROM=3: required: exactly 3 cycles in 0x2 before 0x3.
